// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
//   Shared definitions for the JK excitation driver:
//     state_t    - controller states (IDLE / DRIVE / CHECK)
//     JK_HOLD    - {J,K} code that leaves Q unchanged
//     JK_SET     - {J,K} code that forces Q to 1
//     JK_CLEAR   - {J,K} code that forces Q to 0
//   The toggle code J=K=1 is deliberately absent: every transition of the
//   excitation table can be reached with a set, clear or hold, so the
//   don't-care entries are resolved to 0.
// ---------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Encoding is {J, K}.
    localparam logic [1:0] JK_HOLD  = 2'b00;
    localparam logic [1:0] JK_SET   = 2'b10;
    localparam logic [1:0] JK_CLEAR = 2'b01;

endpackage

// File: rtl/jk_excite_enc.sv
// ---------------------------------------------------------------------------
// jk_excite_enc
//   Pure combinational JK excitation table: given the current Q (cur) and
//   the desired next Q (nxt), produce the J/K inputs that make a JK
//   flip-flop take that transition.
//   Ports:
//     cur  in   current Q of the flip-flop
//     nxt  in   desired next Q
//     j    out  J excitation
//     k    out  K excitation
// ---------------------------------------------------------------------------
module jk_excite_enc
    import jk_pkg::*;
(
    input  logic cur,
    input  logic nxt,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code = JK_HOLD;
        case ({cur, nxt})
            2'b01:   code = JK_SET;
            2'b10:   code = JK_CLEAR;
            default: code = JK_HOLD;
        endcase
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_excite_drv.sv
// ---------------------------------------------------------------------------
// jk_excite_drv
//   Drives the J/K inputs of a downstream JK flip-flop so that its Q follows
//   a stream of target bits. Each accepted target produces a single-cycle
//   J/K excitation; with JK_CHECK_EN defined the fed-back Q is then compared
//   against the expected value and mismatches are counted.
//
//   Configuration macro: JK_CHECK_EN
//     defined   : IDLE -> DRIVE -> CHECK -> IDLE, one target per 3 cycles,
//                 q_fb checked, err_cnt/err/clr_err active.
//     undefined : IDLE -> DRIVE -> IDLE, one target per 2 cycles,
//                 err_cnt/err tied to 0, q_fb and clr_err ignored.
//
//   Parameters:
//     ERR_W      width of the saturating mismatch counter (2..16)
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous reset, active low
//     tgt_valid  in   a target Q bit is offered
//     tgt_bit    in   desired next Q of the flip-flop
//     tgt_ready  out  target accepted this cycle (high only in IDLE)
//     q_fb       in   Q fed back from the flip-flop
//     clr_err    in   synchronous clear of err_cnt and err
//     J, K       out  registered excitation to the flip-flop
//     done       out  one-cycle pulse at the end of each transaction
//     err_cnt    out  saturating mismatch count
//     err        out  sticky mismatch flag
// ---------------------------------------------------------------------------
module jk_excite_drv
    import jk_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    input  logic             clr_err,
    output logic             J,
    output logic             K,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err
);

    state_t state;
    logic   m_q;     // model of the flip-flop's Q after the last transaction
    logic   m_next;  // target being applied in the current transaction
    logic   enc_j;
    logic   enc_k;
    logic   accept;

    // The table is evaluated against the incoming target so that J/K can be
    // registered on the accepting edge itself.
    jk_excite_enc u_enc (
        .cur (m_q),
        .nxt (tgt_bit),
        .j   (enc_j),
        .k   (enc_k)
    );

    assign tgt_ready = (state == ST_IDLE);
    assign accept    = tgt_valid & tgt_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            J      <= 1'b0;
            K      <= 1'b0;
            done   <= 1'b0;
            m_q    <= 1'b0;
            m_next <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        m_next <= tgt_bit;
                        J      <= enc_j;
                        K      <= enc_k;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Excitation lasts exactly one cycle; the flip-flop has
                    // now taken the transition, so m_q advances.
                    J   <= 1'b0;
                    K   <= 1'b0;
                    m_q <= m_next;
`ifdef JK_CHECK_EN
                    state <= ST_CHECK;
`else
                    done  <= 1'b1;
                    state <= ST_IDLE;
`endif
                end
                ST_CHECK: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JK_CHECK_EN
    logic mismatch;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    assign mismatch = (state == ST_CHECK) && (q_fb != m_q);

    // clr_err takes priority over a simultaneous mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (clr_err) begin
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            err     <= 1'b1;
        end
    end
`else
    logic unused_check_inputs;

    assign unused_check_inputs = q_fb ^ clr_err;
    assign err_cnt = '0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excite_drv.sv
// ---------------------------------------------------------------------------
// tb_jk_excite_drv
//   Self-checking bench for jk_excite_drv. A behavioural JK flip-flop sits
//   downstream of the driver and feeds q_fb back; its output can be
//   overridden to force mismatches. Expected J/K, done, ready and error
//   state come from a transaction-level model of the driver's rules.
// ---------------------------------------------------------------------------
module tb_jk_excite_drv;

    localparam int EW = 2;
    localparam int SAT = (1 << EW) - 1;
`ifdef JK_CHECK_EN
    localparam int PER = 3;
`else
    localparam int PER = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tgt_valid = 1'b0;
    logic          tgt_bit = 1'b0;
    logic          clr_err = 1'b0;
    logic          tgt_ready;
    logic          q_fb;
    logic          J;
    logic          K;
    logic          done;
    logic          err;
    logic [EW-1:0] err_cnt;

    logic q_ff;
    logic q_force = 1'b0;
    logic force_val = 1'b0;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit mq = 1'b0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    // Behavioural downstream JK flip-flop, reset to Q=0.
    always @(posedge clk or negedge rst) begin
        if (!rst)          q_ff <= 1'b0;
        else if (J && K)   q_ff <= ~q_ff;
        else if (J)        q_ff <= 1'b1;
        else if (K)        q_ff <= 1'b0;
    end

    assign q_fb = q_force ? force_val : q_ff;

    jk_excite_drv #(.ERR_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .q_fb      (q_fb),
        .clr_err   (clr_err),
        .J         (J),
        .K         (K),
        .done      (done),
        .err_cnt   (err_cnt),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (tgt_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", tgt_ready, 1);
    endtask

    task automatic check_err_state(input string tag);
        check({tag, "_cnt"}, err_cnt, m_cnt);
        check({tag, "_err"}, err, m_err);
    endtask

    // One complete transaction: target b, optional forced Q mismatch,
    // optional clr_err in the compare cycle.
    task automatic do_txn(input bit b, input bit mis, input bit clr);
        wait_ready();
        tgt_valid = 1'b1;
        tgt_bit   = b;
        q_force   = mis;
        force_val = ~b;
        tick();                                   // accepting edge
        tgt_valid = 1'b0;
        tgt_bit   = 1'($urandom_range(0, 1));
        check("txn_j", J, (b > mq));              // J only for a 0->1 move
        check("txn_k", K, (b < mq));              // K only for a 1->0 move
        check("txn_busy", tgt_ready, 0);
        check("txn_done_lo", done, 0);
        mq = b;
        tick();                                   // excitation edge
        check("txn_j_off", J, 0);
        check("txn_k_off", K, 0);
`ifdef JK_CHECK_EN
        check("txn_done_mid", done, 0);
        clr_err = clr;
        tick();                                   // compare edge
        clr_err = 1'b0;
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else if (mis) begin
            m_cnt = (m_cnt >= SAT) ? SAT : m_cnt + 1;
            m_err = 1'b1;
        end
`endif
        check("txn_done", done, 1);
        check("txn_ready", tgt_ready, 1);
        check_err_state("txn");
        q_force = 1'b0;
    endtask

    task automatic clear_step();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        check_err_state("clr");
    endtask

    initial begin
        bit seq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int since;
        bit b_cur;
        bit acc;
        bit b;
        int exp_sat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_j", J, 0);
        check("rst_k", K, 0);
        check("rst_done", done, 0);
        check("rst_cnt", err_cnt, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();
        check("rst_ready", tgt_ready, 1);

        // Directed sequence 1,1,0,0,1 against a correct flip-flop
        foreach (seq[i]) do_txn(seq[i], 1'b0, 1'b0);
        check("seq_q", q_fb, 1);

        // tgt_valid held high: accepts spaced PER cycles, J/K one cycle each
        wait_ready();
        b_cur     = 1'($urandom_range(0, 1));
        tgt_bit   = b_cur;
        tgt_valid = 1'b1;
        since     = PER;
        for (int c = 0; c < 15; c++) begin
            acc = (since >= PER);
            check("cont_ready", tgt_ready, acc);
            if (c > 0) check("cont_done", done, (since == PER));
            tick();
            if (acc) begin
                check("cont_j", J, (b_cur > mq));
                check("cont_k", K, (b_cur < mq));
                mq      = b_cur;
                since   = 1;
                b_cur   = 1'($urandom_range(0, 1));
                tgt_bit = b_cur;
            end else begin
                check("cont_j_off", J, 0);
                check("cont_k_off", K, 0);
                since++;
            end
        end
        tgt_valid = 1'b0;
        wait_ready();
        check_err_state("cont");

        // Forced Q=0 while driving a 1, then clear
        clear_step();
        do_txn(1'b1, 1'b1, 1'b0);
        clear_step();

        // Saturation: seven forced mismatches
        for (int i = 0; i < 7; i++) do_txn(1'($urandom_range(0, 1)), 1'b1, 1'b0);
`ifdef JK_CHECK_EN
        exp_sat = SAT;
`else
        exp_sat = 0;
`endif
        check("sat_cnt", err_cnt, exp_sat);

        // Clear in the same cycle as a mismatch
        do_txn(~mq, 1'b1, 1'b1);
        check("clr_same_err", err, 0);

        // Reset during DRIVE
        wait_ready();
        b = ~mq;
        tgt_valid = 1'b1;
        tgt_bit   = b;
        tick();
        tgt_valid = 1'b0;
        check("abort_j", J, (b > mq));
        check("abort_k", K, (b < mq));
        #1 rst = 1'b0;
        #1;
        check("abort_j_off", J, 0);
        check("abort_k_off", K, 0);
        check("abort_ready", tgt_ready, 1);
        check("abort_cnt", err_cnt, 0);
        #1 rst = 1'b1;
        mq = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_idle_j", J, 0);
        end
        do_txn(1'b1, 1'b0, 1'b0);

        // Randomised transactions
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_excite_drv.md
JK_EXCITE_DRV -- requirements
Module: jk_excite_drv

Interface
REQ-001 Parameter ERR_W, default 8, width of the mismatch counter (legal range 2..16).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 tgt_valid  input  1  a target Q bit is offered.
REQ-005 tgt_bit  input  1  the desired next Q of the downstream JK flip-flop.
REQ-006 tgt_ready  output  1  the driver accepts a target this cycle.
REQ-007 q_fb  input  1  Q fed back from the downstream JK flip-flop.
REQ-008 clr_err  input  1  synchronous clear of err_cnt and err.
REQ-009 J  output  1  registered J drive to the flip-flop.
REQ-010 K  output  1  registered K drive to the flip-flop.
REQ-011 done  output  1  one-cycle pulse when a target transaction completes.
REQ-012 err_cnt  output  ERR_W  saturating count of Q mismatches.
REQ-013 err  output  1  sticky flag, set on any mismatch.

Function
REQ-014 The FSM states SHALL be IDLE, DRIVE and CHECK; tgt_ready SHALL be high only in IDLE.
REQ-015 Accept: tgt_valid&tgt_ready at edge E0 -> latch tgt_bit as m_next, register J/K, go to DRIVE.
REQ-016 Excitation from (m_q, m_next): 0->0 J=0 K=0; 0->1 J=1 K=0; 1->0 J=0 K=1; 1->1 J=0 K=0 (don't-cares resolved to 0, never J=K=1).
REQ-017 DRIVE: J/K held for exactly one cycle; at E1 J=K=0, m_q<=m_next, go to CHECK.
REQ-018 CHECK: at E2 compare q_fb with m_q; on mismatch err_cnt+1 (saturate at 2^ERR_W-1) and err<=1; done pulses for the cycle after E2; go to IDLE.
REQ-019 Throughput SHALL be one target per 3 cycles; tgt_ready rises the cycle after E2.
REQ-020 tgt_valid while tgt_ready is low SHALL be ignored; the source holds tgt_bit until accepted.
REQ-021 clr_err together with a mismatch in the same cycle: clear wins, err_cnt=0 and err=0.
REQ-022 err_cnt at saturation SHALL hold; err stays set until clr_err or reset.

Reset
REQ-023 rst low SHALL immediately force: state IDLE, J=0, K=0, done=0, m_q=0, m_next=0, err_cnt=0, err=0; tgt_ready=1 after release.
REQ-024 Reset mid-transaction (DRIVE or CHECK) SHALL abort it with no err_cnt update and no done pulse.
REQ-025 m_q=0 after reset matches the downstream flip-flop reset value of Q=0.

Configuration
REQ-026 Macro JK_CHECK_EN: when defined, CHECK state, q_fb comparison, err_cnt, err and clr_err behave as above.
REQ-027 Without JK_CHECK_EN: DRIVE goes directly to IDLE with done pulsing after E1, throughput is one target per 2 cycles, err_cnt and err are tied to 0, and q_fb and clr_err are unused.

Structure
REQ-028 A shared package jk_pkg SHALL hold the FSM state enum and the excitation-encoding constants.
REQ-029 The excitation table SHALL be a sub-module jk_excite_enc, a pure combinational (m_q, m_next) -> (J, K) map instantiated once.

Verification
REQ-030 Reset, then the target sequence 1,1,0,0,1 against a correct jk_ff -> J/K pairs 10,00,01,00,10; err_cnt=0; five done pulses.
REQ-031 tgt_valid held high continuously -> accepts spaced exactly 3 cycles apart (2 without JK_CHECK_EN); J/K each high for exactly one cycle.
REQ-032 q_fb forced to 0 while target=1 is driven -> err=1, err_cnt=1 after E2; a following clr_err -> both 0.
REQ-033 With ERR_W=2, seven forced mismatches -> err_cnt sticks at 3.
REQ-034 rst asserted low during DRIVE -> J=K=0 asynchronously, no done pulse; the next accept starts from m_q=0.
REQ-035 clr_err asserted in the same cycle as a mismatch -> err_cnt=0 and err=0.
